// File: rtl/pipe_slice_reg.sv
// Elastic two-entry skid register between series-evaluator datapath stages.
// With SEED=1 it heads the pipeline: x passes through and num/sum/overflow/i are seeded.
module pipe_slice_reg #(
  parameter bit          SEED     = 1'b0,
  parameter logic [31:0] NUM_INIT = 32'h7FFF_FFFF,
  parameter logic [31:0] SUM_INIT = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_x,
  input  logic signed [31:0] in_num,
  input  logic signed [31:0] in_sum,
  input  logic               in_overflow,
  input  logic [2:0]         in_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_x,
  output logic signed [31:0] out_num,
  output logic signed [31:0] out_sum,
  output logic               out_overflow,
  output logic [2:0]         out_i
);

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] num;
    logic [DATA_W-1:0] sum;
    logic              ovf;
    logic [2:0]        i;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e  state_q;
  bundle_t main_q;
  bundle_t skid_q;
  bundle_t in_b;
  logic    accept;
  logic    emit;

  // The head stage keeps only x; the remaining fields start the series.
  function automatic bundle_t capture(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] num,
    input logic [DATA_W-1:0] sum,
    input logic              ovf,
    input logic [2:0]        i
  );
    bundle_t b;
    b.x = x;
    if (SEED) begin
      b.num = NUM_INIT;
      b.sum = SUM_INIT;
      b.ovf = 1'b0;
      b.i   = 3'b000;
    end else begin
      b.num = num;
      b.sum = sum;
      b.ovf = ovf;
      b.i   = i;
    end
    return b;
  endfunction

  assign in_b      = capture(in_x, in_num, in_sum, in_overflow, in_i);
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL) & ~rst;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_b;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= in_b;
          end else if (accept) begin
            skid_q  <= in_b;
            state_q <= FULL;
          end else if (emit) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (emit) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_x        = main_q.x;
  assign out_num      = main_q.num;
  assign out_sum      = main_q.sum;
  assign out_overflow = main_q.ovf;
  assign out_i        = main_q.i;

endmodule

// File: tb/tb_pipe_slice_reg.sv
// Bench for pipe_slice_reg: a plain and a seeded instance share stimulus and are
// compared each cycle against FIFO models of at most two entries.
module tb_pipe_slice_reg;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] num;
    logic [31:0] sum;
    logic        ovf;
    logic [2:0]  i;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    flush = 1'b0;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  bundle_t din = '0;

  logic        rdy0, vld0, ovf0;
  logic [31:0] x0, num0, sum0;
  logic [2:0]  i0;
  logic        rdy1, vld1, ovf1;
  logic [31:0] x1, num1, sum1;
  logic [2:0]  i1;

  int checks = 0;
  int errors = 0;

  bundle_t q0[$];
  bundle_t q1[$];

  always #5 clk = ~clk;

  pipe_slice_reg #(.SEED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_x(din.x), .in_num(din.num), .in_sum(din.sum),
    .in_overflow(din.ovf), .in_i(din.i),
    .out_valid(vld0), .out_ready(out_ready),
    .out_x(x0), .out_num(num0), .out_sum(sum0),
    .out_overflow(ovf0), .out_i(i0)
  );

  pipe_slice_reg #(.SEED(1'b1)) u_seed (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_x(din.x), .in_num(din.num), .in_sum(din.sum),
    .in_overflow(din.ovf), .in_i(din.i),
    .out_valid(vld1), .out_ready(out_ready),
    .out_x(x1), .out_num(num1), .out_sum(sum1),
    .out_overflow(ovf1), .out_i(i1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [31:0] x, input logic [31:0] num,
                                 input logic [31:0] sum, input logic ovf,
                                 input logic [2:0] i);
    bundle_t b;
    b.x = x; b.num = num; b.sum = sum; b.ovf = ovf; b.i = i;
    return b;
  endfunction

  function automatic bundle_t seeded(input bundle_t b);
    return mk(b.x, 32'h7FFF_FFFF, 32'h0, 1'b0, 3'd0);
  endfunction

  // Outputs must show the oldest held bundle; ready means room for another.
  task automatic check_model();
    bundle_t o0, o1;
    o0 = mk(x0, num0, sum0, ovf0, i0);
    o1 = mk(x1, num1, sum1, ovf1, i1);
    check("valid0", 128'(vld0), 128'(q0.size() != 0));
    check("ready0", 128'(rdy0), 128'(q0.size() < 2));
    check("valid1", 128'(vld1), 128'(q1.size() != 0));
    check("ready1", 128'(rdy1), 128'(q1.size() < 2));
    if (q0.size() != 0) check("data0", 128'(o0), 128'(q0[0]));
    if (q1.size() != 0) check("data1", 128'(o1), 128'(q1[0]));
  endtask

  // Drive after a falling edge, advance the model on the rising edge, check at the next fall.
  task automatic step(input logic v, input logic r, input logic f, input bundle_t b);
    bit acc, emt;
    in_valid  = v;
    out_ready = r;
    flush     = f;
    din       = b;
    acc = v && (q0.size() < 2);
    emt = (q0.size() != 0) && r;
    @(posedge clk);
    if (f) begin
      q0.delete();
      q1.delete();
    end else begin
      if (emt) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (acc) begin
        q0.push_back(b);
        q1.push_back(seeded(b));
      end
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic bundle_t rnd();
    return mk($urandom, $urandom, $urandom, 1'($urandom), 3'($urandom));
  endfunction

  initial begin
    #1;
    check("rst_valid", 128'(vld0), 128'(0));
    check("rst_ready", 128'(rdy0), 128'(0));
    check("rst_sum", 128'(sum0), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    check("rel_ready", 128'(rdy0), 128'(1));

    // Streaming at full rate.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 1'b0, mk(32'h0, 32'h0, 32'(k), 1'b0, 3'd0));
      check("stream_sum", 128'(sum0), 128'(k));
      check("stream_ready", 128'(rdy0), 128'(1));
    end
    step(1'b0, 1'b1, 1'b0, '0);

    // Backpressure fills the skid entry, then drains in order.
    step(1'b1, 1'b0, 1'b0, mk(32'h0, 32'h0, 32'h1000_0000, 1'b0, 3'd0));
    step(1'b1, 1'b0, 1'b0, mk(32'h0, 32'h0, 32'h2000_0000, 1'b0, 3'd0));
    check("bp_full_ready", 128'(rdy0), 128'(0));
    check("bp_hold_a", 128'(sum0), 128'(32'h1000_0000));
    step(1'b0, 1'b0, 1'b0, '0);
    check("bp_still_a", 128'(sum0), 128'(32'h1000_0000));
    step(1'b0, 1'b1, 1'b0, '0);
    check("bp_then_b", 128'(sum0), 128'(32'h2000_0000));
    check("bp_ready_back", 128'(rdy0), 128'(1));
    step(1'b0, 1'b1, 1'b0, '0);
    check("bp_drained", 128'(vld0), 128'(0));

    // Simultaneous accept and emit keeps a single entry.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, mk(32'h0, 32'h0, 32'h0, 1'b0, 3'(k % 8)));
      check("thru_i", 128'(i0), 128'(k % 8));
      check("thru_ready", 128'(rdy0), 128'(1));
    end
    step(1'b0, 1'b1, 1'b0, '0);

    // Seeded head stage.
    step(1'b1, 1'b1, 1'b0, mk(32'h4000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 3'd5));
    check("seed_x", 128'(x1), 128'(32'h4000_0000));
    check("seed_num", 128'(num1), 128'(32'h7FFF_FFFF));
    check("seed_sum", 128'(sum1), 128'(0));
    check("seed_i", 128'(i1), 128'(0));
    check("seed_ovf", 128'(ovf1), 128'(0));
    check("seed_plain_i", 128'(i0), 128'(5));
    step(1'b0, 1'b1, 1'b0, '0);

    // Flush while full, with a bundle offered in the same cycle.
    step(1'b1, 1'b0, 1'b0, rnd());
    step(1'b1, 1'b0, 1'b0, rnd());
    step(1'b1, 1'b0, 1'b1, rnd());
    check("flush_valid", 128'(vld0), 128'(0));
    check("flush_ready", 128'(rdy0), 128'(1));
    step(1'b1, 1'b0, 1'b0, mk(32'h0, 32'h0, 32'h0000_0055, 1'b0, 3'd0));
    check("flush_next", 128'(sum0), 128'(32'h55));
    step(1'b0, 1'b1, 1'b0, '0);
    check("flush_alone", 128'(vld0), 128'(0));

    // Asynchronous reset while full.
    step(1'b1, 1'b0, 1'b0, mk(32'h1, 32'h2, 32'h3333, 1'b1, 3'd3));
    step(1'b1, 1'b0, 1'b0, mk(32'h4, 32'h5, 32'h6666, 1'b0, 3'd6));
    check("pre_rst_ready", 128'(rdy0), 128'(0));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 128'(vld0), 128'(0));
    check("arst_sum", 128'(sum0), 128'(0));
    check("arst_ready", 128'(rdy0), 128'(0));
    check("arst_seed_x", 128'(x1), 128'(0));
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    check("arst_rel_ready", 128'(rdy0), 128'(1));

    // Random traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      step(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), rnd());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_slice_reg.md
Name: pipe_slice_reg

Overview:
- Elastic pipeline register between two consecutive pipe_slice_dp stages of the fixed-point series evaluator.
- Carries one bundle per beat: x, num, sum, overflow, i.
- 2-entry skid buffer with valid/ready on both sides, so backpressure never drops or duplicates a bundle and in_ready has no combinational path from out_ready.
- With SEED=1 it is the pipeline head: it takes only in_x and injects the series start values.

Parameters:
- SEED, 0, 1 = head stage: ignore in_num/in_sum/in_i/in_overflow and capture the seed values below.
- NUM_INIT, 32'h7FFF_FFFF, Q1.31 num captured when SEED=1 (≈1.0).
- SUM_INIT, 32'h0000_0000, Q1.31 sum captured when SEED=1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear; discards all held bundles
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- in_x  in  32  signed Q1.31 x
- in_num  in  32  signed Q1.31 running power term
- in_sum  in  32  signed Q1.31 partial sum
- in_overflow  in  1  sticky overflow
- in_i  in  3  term index
- out_valid  out  1  out_* hold a valid bundle
- out_ready  in  1  downstream accepts
- out_x  out  32  registered x
- out_num  out  32  registered num
- out_sum  out  32  registered sum
- out_overflow  out  1  registered overflow
- out_i  out  3  registered index

Behaviour:
- Storage: main register (drives out_*) and skid register, each 100 bits (3×32 + 1 + 3).
- FSM state register, states:
  - EMPTY: nothing held.
  - ONE: main valid.
  - FULL: main and skid valid.
- Derived signals:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL) & ~rst.
  - Both decode registered state only.
- Transfers:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
- Transitions (rising clk):
  - EMPTY: accept -> main<=in, ONE.
  - ONE: accept & emit -> main<=in, ONE. accept & ~emit -> skid<=in, FULL. ~accept & emit -> EMPTY. Otherwise hold.
  - FULL: emit -> main<=skid, ONE. Otherwise hold. No accept is possible because in_ready=0.
- Latency and throughput:
  - Latency is 1 cycle: a bundle accepted at edge k is on out_* after edge k.
  - Throughput is 1 bundle/cycle while out_ready=1.
- Data rules:
  - Bundles pass bit-exact with no arithmetic and no reordering.
  - out_* stay stable while out_valid=1 and out_ready=0.
- SEED=1 capture value: {in_x, NUM_INIT, SUM_INIT, overflow=0, i=3'b000}. Skid and main both store this seeded form.
- Reset (async, any time, including mid-transfer):
  - state=EMPTY.
  - Main and skid registers = 0, so all out_* = 0.
  - out_valid=0; in_ready=0 while rst is high, 1 on the first cycle after release.
  - Held bundles are lost.
- flush (sync):
  - Next state = EMPTY, regardless of accept/emit in that cycle.
  - The incoming bundle is dropped. out_* data is not required to clear; out_valid=0.
  - flush has priority over all transitions.
- Treat in_valid as X-tolerant when in_ready=0. Data inputs are ignored unless accept.

Test Plan:
1. Reset mid-stream: state FULL, assert rst asynchronously between edges -> out_valid=0, out_sum=0, in_ready=0 immediately; in_ready=1 one cycle after release.
2. Streaming with out_ready=1: push sum=1..8 on consecutive cycles -> out_sum=1..8 on consecutive cycles, each one cycle after accept, in_ready constantly 1.
3. Backpressure:
   - Push A (sum=32'h1000_0000) and B (sum=32'h2000_0000) with out_ready=0 -> state FULL, in_ready=0, out_sum holds A.
   - Raise out_ready -> A, then B emitted in order.
   - No loss or duplication; in_ready returns to 1 after the first emit.
4. Simultaneous accept/emit in ONE: out_ready=1, in_valid=1 every cycle for 10 cycles with i=0..7,0,1 -> out_i follows the same sequence delayed one cycle, and the stage never goes FULL.
5. SEED=1: in_x=32'h4000_0000, in_num=32'h1234_5678, in_sum=32'hDEAD_BEEF, in_i=5, in_overflow=1 -> out_x=32'h4000_0000, out_num=32'h7FFF_FFFF, out_sum=0, out_i=0, out_overflow=0.
6. flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1. The next accepted bundle (sum=32'h0000_0055) appears alone on out_sum.
